// File: rtl/switch_sequencer.sv
// switch_sequencer: sequences CPU A/B switchover on an idle UART boundary of the active CPU.
// Define SWSEQ_FAULT_CNT_EN to compile in fault counters, rescaling and count-based preference.
module switch_sequencer #(
  parameter int IDLE_CYC  = 160,
  parameter int DRAIN_MAX = 4096,
  parameter int HOLD_CYC  = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_a,
  input  logic       io_b,
  input  logic       force_swi,
  input  logic       com_swi,
  input  logic       err_clr,
  input  logic       srx_cpuA,
  input  logic       srx_cpuB,
  output logic       switch,
  output logic       busy,
  output logic [7:0] a_err_num,
  output logic [7:0] b_err_num,
  output logic [7:0] swi_count
);
  typedef enum logic [1:0] {ACT_A, DRAIN_B, ACT_B, DRAIN_A} state_t;
  localparam logic [16:0] L_IDLE  = 17'(IDLE_CYC);
  localparam logic [16:0] L_DRAIN = 17'(DRAIN_MAX);
  localparam logic [15:0] L_HOLD  = 16'(HOLD_CYC);
  state_t      r_state;
  logic [1:0]  r_ioa_s, r_iob_s, r_rxa_s, r_rxb_s;
  logic        r_switch, r_busy;
  logic [7:0]  r_swc;
  logic [15:0] r_idle, r_drain, r_hold;
  logic        w_fault_a, w_fault_b, w_line, w_done, w_toggle;
  logic        w_tgt, w_req, w_cnt_gt, w_cnt_lt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ioa_s <= '1;
      r_iob_s <= '1;
      r_rxa_s <= '1;
      r_rxb_s <= '1;
    end else begin
      r_ioa_s <= {r_ioa_s[0], io_a};
      r_iob_s <= {r_iob_s[0], io_b};
      r_rxa_s <= {r_rxa_s[0], srx_cpuA};
      r_rxb_s <= {r_rxb_s[0], srx_cpuB};
    end
  assign w_fault_a = ~r_ioa_s[1];
  assign w_fault_b = ~r_iob_s[1];
`ifdef SWSEQ_FAULT_CNT_EN
  logic       r_fa_d, r_fb_d;
  logic [7:0] r_a_err, r_b_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_fa_d  <= 1'b0;
      r_fb_d  <= 1'b0;
      r_a_err <= '0;
      r_b_err <= '0;
    end else begin
      r_fa_d <= w_fault_a;
      r_fb_d <= w_fault_b;
      if (err_clr || force_swi) begin
        r_a_err <= '0;
        r_b_err <= '0;
      end else if (&r_a_err || &r_b_err) begin
        r_a_err <= {7'd0, w_cnt_gt};
        r_b_err <= {7'd0, ~w_cnt_gt};
      end else begin
        r_a_err <= r_a_err + {7'd0, w_fault_a & ~r_fa_d};
        r_b_err <= r_b_err + {7'd0, w_fault_b & ~r_fb_d};
      end
    end
  assign w_cnt_gt  = r_a_err > r_b_err;
  assign w_cnt_lt  = r_a_err < r_b_err;
  assign a_err_num = r_a_err;
  assign b_err_num = r_b_err;
`else
  logic w_unused;
  assign w_unused  = err_clr;
  assign w_cnt_gt  = 1'b0;
  assign w_cnt_lt  = 1'b0;
  assign a_err_num = '0;
  assign b_err_num = '0;
`endif
  // a single faulty CPU always loses; both faulty means stay put
  always_comb begin
    w_tgt = r_switch;
    w_req = 1'b0;
    if (w_fault_a != w_fault_b) begin
      w_tgt = w_fault_a;
      w_req = 1'b1;
    end else if (!w_fault_a && force_swi) begin
      w_tgt = com_swi;
      w_req = 1'b1;
    end else if (!w_fault_a && (w_cnt_gt != w_cnt_lt)) begin
      w_tgt = w_cnt_gt;
      w_req = (r_hold == '0);
    end
  end
  assign w_line   = r_switch ? r_rxb_s[1] : r_rxa_s[1];
  assign w_done   = ({1'b0, r_idle} >= L_IDLE) || (({1'b0, r_drain} + 17'd1) >= L_DRAIN);
  assign w_toggle = r_busy && w_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= ACT_A;
      r_switch <= 1'b0;
      r_busy   <= 1'b0;
      r_swc    <= '0;
      r_idle   <= '0;
      r_drain  <= '0;
      r_hold   <= '0;
    end else begin
      r_idle <= (w_toggle || !w_line) ? '0 : r_idle + {15'd0, r_idle != 16'hFFFF};
      r_hold <= (r_hold != '0) ? r_hold - 16'd1 : '0;
      case (r_state)
        ACT_A, ACT_B:
          if (w_req && (w_tgt != r_switch)) begin
            r_state <= r_switch ? DRAIN_A : DRAIN_B;
            r_busy  <= 1'b1;
            r_drain <= '0;
          end
        default:
          if (w_done) begin
            r_state  <= r_switch ? ACT_A : ACT_B;
            r_switch <= ~r_switch;
            r_busy   <= 1'b0;
            r_swc    <= r_swc + 8'd1;
            r_hold   <= L_HOLD;
          end else if (w_tgt == r_switch) begin
            r_state <= r_switch ? ACT_B : ACT_A;
            r_busy  <= 1'b0;
          end else begin
            r_drain <= r_drain + 16'd1;
          end
      endcase
    end
  assign switch    = r_switch;
  assign busy      = r_busy;
  assign swi_count = r_swc;
endmodule

// File: tb/tb_switch_sequencer.sv
// tb_switch_sequencer: table vectors, hand sequences and random stimulus against a reference model.
module tb_switch_sequencer;
  localparam int IDLE = 6, DRN = 20, HOLD = 30;
`ifdef SWSEQ_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, io_a = 1, io_b = 1, force_swi = 0, com_swi = 0, err_clr = 0;
  logic srx_cpuA = 1, srx_cpuB = 1;
  logic switch, busy;
  logic [7:0] a_err_num, b_err_num, swi_count;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  switch_sequencer #(.IDLE_CYC(IDLE), .DRAIN_MAX(DRN), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .io_a(io_a), .io_b(io_b), .force_swi(force_swi),
    .com_swi(com_swi), .err_clr(err_clr), .srx_cpuA(srx_cpuA), .srx_cpuB(srx_cpuB),
    .switch(switch), .busy(busy), .a_err_num(a_err_num), .b_err_num(b_err_num),
    .swi_count(swi_count)
  );

  typedef struct { bit ioa, iob, rxa, rxb; } samp_t;
  samp_t hist[$];
  int m_sel, m_drain, m_dwell, m_idle, m_hold, m_swc, m_a, m_b;

  task automatic mreset();
    samp_t one;
    one = '{1'b1, 1'b1, 1'b1, 1'b1};
    hist = {one, one, one};
    m_sel = 0; m_drain = 0; m_dwell = 0; m_idle = 0; m_hold = 0; m_swc = 0; m_a = 0; m_b = 0;
  endtask

  // inputs are seen two edges late; the fault edge compares against three edges late
  task automatic model_edge();
    samp_t s, p;
    bit fa, fb, pfa, pfb, line, req, done;
    int tgt;
    s = hist[$-1]; p = hist[$-2];
    fa = !s.ioa; fb = !s.iob; pfa = !p.ioa; pfb = !p.iob;
    line = (m_sel == 1) ? s.rxb : s.rxa;
    tgt = m_sel; req = 0; done = 0;
    if (fa && !fb) begin tgt = 1; req = 1; end
    else if (fb && !fa) begin tgt = 0; req = 1; end
    else if (!fa && force_swi) begin tgt = int'(com_swi); req = 1; end
    else if (!fa && CNT_EN && m_a != m_b) begin tgt = (m_a > m_b) ? 1 : 0; req = (m_hold == 0); end
    if (m_drain == 0) begin
      if (req && tgt != m_sel) begin m_drain = 1; m_dwell = 0; end
    end else if (m_idle >= IDLE || m_dwell + 1 >= DRN) begin
      done = 1; m_drain = 0; m_sel = 1 - m_sel;
    end else if (tgt == m_sel) m_drain = 0;
    else m_dwell++;
    m_hold = done ? HOLD : (m_hold > 0 ? m_hold - 1 : 0);
    if (done) m_swc = (m_swc + 1) % 256;
    m_idle = (done || !line) ? 0 : (m_idle < 65535 ? m_idle + 1 : m_idle);
    if (CNT_EN) begin
      if (err_clr || force_swi) begin m_a = 0; m_b = 0; end
      else if (m_a == 255 || m_b == 255) begin
        if (m_a > m_b) begin m_a = 1; m_b = 0; end else begin m_a = 0; m_b = 1; end
      end else begin
        m_a += (fa && !pfa) ? 1 : 0;
        m_b += (fb && !pfb) ? 1 : 0;
      end
    end
    hist.push_back('{io_a, io_b, srx_cpuA, srx_cpuB});
    void'(hist.pop_front());
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0d want=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("switch", int'(switch), m_sel);
    chk("busy", int'(busy), m_drain);
    chk("swi_count", int'(swi_count), m_swc);
    chk("a_err_num", int'(a_err_num), m_a);
    chk("b_err_num", int'(b_err_num), m_b);
  endtask

  task automatic step();
    @(posedge clk);
    #1 model_edge();
    @(negedge clk);
    chk_model();
  endtask

  typedef struct { int ioa, iob, frc, com, rxa, rxb, n, sw, bz, swc; } vec_t;
  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bcnt;
    // ioa iob frc com rxa rxb  n  sw bz swc  (expected after the n-th edge)
    tbl = '{
      '{1, 1, 0, 0, 1, 1,  9, 0, 0, 0},
      '{0, 1, 0, 0, 1, 1,  1, 0, 0, 0},
      '{0, 1, 0, 0, 1, 1,  1, 0, 0, 0},
      '{0, 1, 0, 0, 1, 1,  1, 0, 1, 0},
      '{0, 1, 0, 0, 1, 1,  1, 1, 0, 1},
      '{0, 1, 0, 0, 1, 1,  5, 1, 0, 1},
      '{1, 0, 0, 0, 1, 0,  2, 1, 0, 1},
      '{1, 0, 0, 0, 1, 0,  1, 1, 1, 1},
      '{1, 1, 0, 0, 1, 0,  2, 1, 1, 1},
      '{1, 1, 0, 0, 1, 0,  1, 1, 0, 1},
      '{1, 1, 0, 0, 1, 1, 10, 1, 0, 1},
      '{1, 1, 1, 0, 1, 1,  1, 1, 1, 1},
      '{1, 1, 1, 0, 1, 1,  1, 0, 0, 2},
      '{1, 1, 1, 0, 1, 1,  3, 0, 0, 2},
      '{1, 1, 0, 0, 1, 1,  3, 0, 0, 2}
    };
    mreset();
    repeat (3) @(negedge clk);
    chk_model();
    rst_n = 1;
    foreach (tbl[i]) begin
      io_a = 1'(tbl[i].ioa); io_b = 1'(tbl[i].iob);
      force_swi = 1'(tbl[i].frc); com_swi = 1'(tbl[i].com);
      srx_cpuA = 1'(tbl[i].rxa); srx_cpuB = 1'(tbl[i].rxb);
      repeat (tbl[i].n) step();
      chk($sformatf("tbl%0d.switch", i), int'(switch), tbl[i].sw);
      chk($sformatf("tbl%0d.busy", i), int'(busy), tbl[i].bz);
      chk($sformatf("tbl%0d.swi_count", i), int'(swi_count), tbl[i].swc);
    end
`ifdef SWSEQ_FAULT_CNT_EN
    chk("counts_zero_after_force", int'(a_err_num) + int'(b_err_num), 0);
`endif

    // busy line on A: drain must time out after exactly DRN cycles
    bcnt = 0;
    io_a = 0;
    for (int c = 0; c < 100 && !switch; c++) begin
      srx_cpuA = ~srx_cpuA;
      step();
      if (busy) bcnt++;
    end
    chk("drain_max_dwell", bcnt, DRN);
    chk("drain_max_switch", int'(switch), 1);
    io_a = 1; srx_cpuA = 1;
    repeat (10) step();

`ifdef SWSEQ_FAULT_CNT_EN
    err_clr = 1; step(); err_clr = 0;
    repeat (3) begin io_b = 0; step(); io_b = 1; step(); end
    repeat (4) step();
    chk("b_three", int'(b_err_num), 3);
    for (int c = 0; c < 2000 && a_err_num != 8'd255; c++) begin
      io_a = (c % 2 == 1);
      step();
    end
    chk("a_at_255", int'(a_err_num), 255);
    io_a = 1;
    step();
    chk("rescale_a", int'(a_err_num), 1);
    chk("rescale_b", int'(b_err_num), 0);
    repeat (5) step();
`endif

    // reach DRAIN_A, then assert reset between clock edges
    force_swi = 1; com_swi = 1;
    for (int c = 0; c < 100 && !(switch && !busy); c++) step();
    force_swi = 0;
    step();
    io_b = 0;
    for (int c = 0; c < 40 && !busy; c++) begin
      srx_cpuB = ~srx_cpuB;
      step();
    end
    chk("pre_reset_drain_a", {30'd0, switch, busy}, 3);
    #2 rst_n = 0;
    #1;
    mreset();
    chk("async_rst_switch", int'(switch), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_swi_count", int'(swi_count), 0);
    chk("async_rst_a_err", int'(a_err_num), 0);
    chk("async_rst_b_err", int'(b_err_num), 0);
    io_a = 1; io_b = 1; srx_cpuA = 1; srx_cpuB = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;

    begin
      bit burst_a, burst_b;
      burst_a = 0; burst_b = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 29) == 0) io_a = ~io_a;
        if ($urandom_range(0, 29) == 0) io_b = ~io_b;
        if ($urandom_range(0, 79) == 0) force_swi = ~force_swi;
        com_swi = 1'($urandom_range(0, 1));
        err_clr = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 19) == 0) burst_a = ~burst_a;
        if ($urandom_range(0, 19) == 0) burst_b = ~burst_b;
        srx_cpuA = burst_a ? 1'($urandom_range(0, 1)) : 1'b1;
        srx_cpuB = burst_b ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
